// File: rtl/updown_counter_param.sv
// Up/down counter with runtime limits, saturate/wrap modes, programmable step and event pulses.
// Optional sticky overflow/underflow status is enabled by defining COUNTER_STICKY_STATUS_EN.
module updown_counter_param #(
  parameter int               WIDTH     = 5,
  parameter int               STEP_W    = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              up,
  input  logic              down,
  input  logic [STEP_W-1:0] step,
  input  logic              wrap_mode,
  input  logic [WIDTH-1:0]  lim_lo,
  input  logic [WIDTH-1:0]  lim_hi,
`ifdef COUNTER_STICKY_STATUS_EN
  input  logic              clr_sticky,
  output logic              sticky_ovf,
  output logic              sticky_unf,
`endif
  output logic [WIDTH-1:0]  counter,
  output logic              high,
  output logic              low,
  output logic              ovf_pulse,
  output logic              unf_pulse
);

  // Wide enough that counter+step and lim_lo+step never wrap for any STEP_W.
  localparam int EW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 2;
  typedef logic [EW-1:0] ext_t;
  localparam ext_t ONE = ext_t'(1);

  logic [WIDTH-1:0] counter_q, counter_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic limits_ok;
  ext_t cnt_x, lo_x, hi_x, step_x, span_x, sum_x, lo_step_x;

  assign limits_ok = (lim_lo <= lim_hi);
  assign cnt_x     = ext_t'(counter_q);
  assign lo_x      = ext_t'(lim_lo);
  assign hi_x      = ext_t'(lim_hi);
  assign step_x    = ext_t'(step);
  assign span_x    = hi_x - lo_x + ONE;
  assign sum_x     = cnt_x + step_x;
  // diff < lim_lo is evaluated as counter < lim_lo + step to stay unsigned.
  assign lo_step_x = lo_x + step_x;

  always_comb begin
    counter_d = counter_q;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    if (load) begin
      if (!limits_ok)            counter_d = load_val;
      else if (load_val < lim_lo) counter_d = lim_lo;
      else if (load_val > lim_hi) counter_d = lim_hi;
      else                        counter_d = load_val;
    end else if ((up || down) && limits_ok && (step != '0)) begin
      if (counter_q < lim_lo) begin
        counter_d = lim_lo;
      end else if (counter_q > lim_hi) begin
        counter_d = lim_hi;
      end else if (down) begin
        if (cnt_x >= lo_step_x) begin
          counter_d = WIDTH'(cnt_x - step_x);
        end else begin
          unf_d = 1'b1;
          if (!wrap_mode)          counter_d = lim_hi == lim_hi ? lim_lo : lim_lo;
          else if (step_x > span_x) counter_d = lim_hi;
          else                      counter_d = WIDTH'(hi_x - (lo_step_x - cnt_x - ONE));
        end
      end else begin
        if (sum_x <= hi_x) begin
          counter_d = WIDTH'(sum_x);
        end else begin
          ovf_d = 1'b1;
          if (!wrap_mode)          counter_d = lim_hi;
          else if (step_x > span_x) counter_d = lim_lo;
          else                      counter_d = WIDTH'(lo_x + (sum_x - hi_x - ONE));
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      counter_q <= RESET_VAL;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      counter_q <= counter_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

`ifdef COUNTER_STICKY_STATUS_EN
  logic sticky_ovf_q, sticky_ovf_d;
  logic sticky_unf_q, sticky_unf_d;

  // A new event on the clearing edge keeps the bit set.
  always_comb begin
    sticky_ovf_d = (sticky_ovf_q && !clr_sticky) || ovf_d;
    sticky_unf_d = (sticky_unf_q && !clr_sticky) || unf_d;
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      sticky_ovf_q <= 1'b0;
      sticky_unf_q <= 1'b0;
    end else begin
      sticky_ovf_q <= sticky_ovf_d;
      sticky_unf_q <= sticky_unf_d;
    end
  end

  assign sticky_ovf = sticky_ovf_q;
  assign sticky_unf = sticky_unf_q;
`endif

  assign counter   = counter_q;
  assign high      = (counter_q >= lim_hi);
  assign low       = (counter_q <= lim_lo);
  assign ovf_pulse = ovf_q;
  assign unf_pulse = unf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param (WIDTH=5, STEP_W=3, RESET_VAL=0).
// Sticky-status checks run only when COUNTER_STICKY_STATUS_EN is defined.
module tb_updown_counter_param;
  logic       clock = 1'b0;
  logic       rst_n;
  logic       load;
  logic [4:0] load_val;
  logic       up, down;
  logic [2:0] step;
  logic       wrap_mode;
  logic [4:0] lim_lo, lim_hi;
  logic [4:0] counter;
  logic       high, low, ovf_pulse, unf_pulse;
`ifdef COUNTER_STICKY_STATUS_EN
  logic       clr_sticky;
  logic       sticky_ovf, sticky_unf;
`endif

  int checks   = 0;
  int failures = 0;

  updown_counter_param #(.WIDTH(5), .STEP_W(3), .RESET_VAL(5'd0)) dut (
    .clock(clock), .rst_n(rst_n), .load(load), .load_val(load_val),
    .up(up), .down(down), .step(step), .wrap_mode(wrap_mode),
    .lim_lo(lim_lo), .lim_hi(lim_hi),
`ifdef COUNTER_STICKY_STATUS_EN
    .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf),
`endif
    .counter(counter), .high(high), .low(low),
    .ovf_pulse(ovf_pulse), .unf_pulse(unf_pulse)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    load = 0; up = 0; down = 0;
`ifdef COUNTER_STICKY_STATUS_EN
    clr_sticky = 0;
`endif
  endtask

  task automatic do_load(input logic [4:0] v);
    idle(); load = 1; load_val = v; tick(); idle();
  endtask

  task automatic test_reset();
    rst_n = 0; idle(); load_val = 0; step = 0; wrap_mode = 0; lim_lo = 0; lim_hi = 31;
`ifdef COUNTER_STICKY_STATUS_EN
    clr_sticky = 0;
`endif
    tick();
    rst_n = 1;
    checks++; if (counter !== 5'd0) begin failures++; $display("FAIL reset_init counter=%0d exp=0", counter); end
    do_load(5'd17);
    checks++; if (counter !== 5'd17) begin failures++; $display("FAIL load17 counter=%0d exp=17", counter); end
    rst_n = 0; up = 1; step = 1; tick(); rst_n = 1; idle();
    checks++; if (counter !== 5'd0 || low !== 1'b1) begin failures++; $display("FAIL reset_mid counter=%0d low=%b exp=0/1", counter, low); end
    checks++; if (ovf_pulse !== 1'b0 || unf_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulses ovf=%b unf=%b exp=0/0", ovf_pulse, unf_pulse); end
  endtask

  task automatic test_saturate();
    wrap_mode = 0; lim_lo = 0; lim_hi = 31;
    do_load(5'd30);
    up = 1; step = 3; tick();
    checks++; if (counter !== 5'd31 || high !== 1'b1 || ovf_pulse !== 1'b1) begin failures++; $display("FAIL sat_up counter=%0d high=%b ovf=%b exp=31/1/1", counter, high, ovf_pulse); end
    tick();
    checks++; if (counter !== 5'd31 || ovf_pulse !== 1'b1) begin failures++; $display("FAIL sat_hold counter=%0d ovf=%b exp=31/1", counter, ovf_pulse); end
    idle(); tick();
    checks++; if (counter !== 5'd31 || ovf_pulse !== 1'b0) begin failures++; $display("FAIL sat_idle counter=%0d ovf=%b exp=31/0", counter, ovf_pulse); end
    lim_lo = 4; lim_hi = 20; do_load(5'd4);
    down = 1; step = 1; tick(); idle();
    checks++; if (counter !== 5'd4 || unf_pulse !== 1'b1 || low !== 1'b1) begin failures++; $display("FAIL sat_down counter=%0d unf=%b low=%b exp=4/1/1", counter, unf_pulse, low); end
    up = 1; step = 0; tick(); idle();
    checks++; if (counter !== 5'd4 || ovf_pulse !== 1'b0 || unf_pulse !== 1'b0) begin failures++; $display("FAIL step0 counter=%0d ovf=%b unf=%b exp=4/0/0", counter, ovf_pulse, unf_pulse); end
  endtask

  task automatic test_wrap();
    wrap_mode = 1; lim_lo = 4; lim_hi = 20;
    do_load(5'd19);
    up = 1; step = 3; tick(); idle();
    checks++; if (counter !== 5'd5 || ovf_pulse !== 1'b1) begin failures++; $display("FAIL wrap_up counter=%0d ovf=%b exp=5/1", counter, ovf_pulse); end
    down = 1; step = 3; tick(); idle();
    checks++; if (counter !== 5'd19 || unf_pulse !== 1'b1 || ovf_pulse !== 1'b0) begin failures++; $display("FAIL wrap_down counter=%0d unf=%b ovf=%b exp=19/1/0", counter, unf_pulse, ovf_pulse); end
    // SPAN=3, step=5 exceeds it
    lim_lo = 4; lim_hi = 6; do_load(5'd5);
    up = 1; step = 5; tick(); idle();
    checks++; if (counter !== 5'd4 || ovf_pulse !== 1'b1) begin failures++; $display("FAIL wrap_bigup counter=%0d ovf=%b exp=4/1", counter, ovf_pulse); end
    down = 1; step = 5; tick(); idle();
    checks++; if (counter !== 5'd6 || unf_pulse !== 1'b1) begin failures++; $display("FAIL wrap_bigdown counter=%0d unf=%b exp=6/1", counter, unf_pulse); end
    wrap_mode = 0;
  endtask

  task automatic test_priority();
    lim_lo = 0; lim_hi = 31; do_load(5'd10);
    up = 1; down = 1; step = 1; tick(); idle();
    checks++; if (counter !== 5'd9 || unf_pulse !== 1'b0) begin failures++; $display("FAIL updown counter=%0d unf=%b exp=9/0", counter, unf_pulse); end
    lim_hi = 20; load = 1; up = 1; load_val = 25; step = 1; tick(); idle();
    checks++; if (counter !== 5'd20 || ovf_pulse !== 1'b0) begin failures++; $display("FAIL load_clamp counter=%0d ovf=%b exp=20/0", counter, ovf_pulse); end
    lim_lo = 9; lim_hi = 8; do_load(5'd25);
    checks++; if (counter !== 5'd25) begin failures++; $display("FAIL load_badlim counter=%0d exp=25", counter); end
  endtask

  task automatic test_out_of_range();
    lim_lo = 0; lim_hi = 31; do_load(5'd15);
    lim_hi = 12; up = 1; step = 1; tick(); idle();
    checks++; if (counter !== 5'd12 || ovf_pulse !== 1'b0) begin failures++; $display("FAIL oor_hi counter=%0d ovf=%b exp=12/0", counter, ovf_pulse); end
    lim_lo = 9; lim_hi = 8; down = 1; step = 1; tick(); idle();
    checks++; if (counter !== 5'd12 || unf_pulse !== 1'b0) begin failures++; $display("FAIL badlim_hold counter=%0d unf=%b exp=12/0", counter, unf_pulse); end
    lim_lo = 14; lim_hi = 20; down = 1; step = 3; tick(); idle();
    checks++; if (counter !== 5'd14 || unf_pulse !== 1'b0) begin failures++; $display("FAIL oor_lo counter=%0d unf=%b exp=14/0", counter, unf_pulse); end
  endtask

  task automatic test_back_to_back();
    lim_lo = 0; lim_hi = 31; wrap_mode = 0; do_load(5'd0);
    up = 1; step = 7;
    tick(); checks++; if (counter !== 5'd7)  begin failures++; $display("FAIL b2b_1 counter=%0d exp=7", counter); end
    tick(); checks++; if (counter !== 5'd14) begin failures++; $display("FAIL b2b_2 counter=%0d exp=14", counter); end
    tick(); checks++; if (counter !== 5'd21 || ovf_pulse !== 1'b0) begin failures++; $display("FAIL b2b_3 counter=%0d ovf=%b exp=21/0", counter, ovf_pulse); end
    up = 0; down = 1; step = 6;
    tick(); checks++; if (counter !== 5'd15) begin failures++; $display("FAIL b2b_4 counter=%0d exp=15", counter); end
    idle();
  endtask

`ifdef COUNTER_STICKY_STATUS_EN
  task automatic test_sticky();
    lim_lo = 0; lim_hi = 31; wrap_mode = 0; do_load(5'd31);
    clr_sticky = 1; tick(); idle();
    checks++; if (sticky_ovf !== 1'b0 || sticky_unf !== 1'b0) begin failures++; $display("FAIL sticky_clr0 ovf=%b unf=%b exp=0/0", sticky_ovf, sticky_unf); end
    up = 1; step = 1; tick(); idle();
    checks++; if (sticky_ovf !== 1'b1 || ovf_pulse !== 1'b1) begin failures++; $display("FAIL sticky_set s=%b p=%b exp=1/1", sticky_ovf, ovf_pulse); end
    tick();
    checks++; if (sticky_ovf !== 1'b1 || ovf_pulse !== 1'b0 || sticky_unf !== 1'b0) begin failures++; $display("FAIL sticky_keep s=%b p=%b u=%b exp=1/0/0", sticky_ovf, ovf_pulse, sticky_unf); end
    clr_sticky = 1; up = 1; step = 1; tick(); idle();
    checks++; if (sticky_ovf !== 1'b1) begin failures++; $display("FAIL sticky_setwins s=%b exp=1", sticky_ovf); end
    clr_sticky = 1; tick(); idle();
    checks++; if (sticky_ovf !== 1'b0) begin failures++; $display("FAIL sticky_clr s=%b exp=0", sticky_ovf); end
  endtask
`endif

  initial begin
    test_reset();
    test_saturate();
    test_wrap();
    test_priority();
    test_out_of_range();
    test_back_to_back();
`ifdef COUNTER_STICKY_STATUS_EN
    test_sticky();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
